result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer_pkg.sv | 19 +
 rtl/result_serializer_if.sv | 34 +++
 rtl/result_serializer_sync_fifo.sv | 70 +++++++
 rtl/result_serializer.sv | 153 +++++++++++++++
 tb/tb_result_serializer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/result_serializer_pkg.sv
// Shared constants and types for the result serializer: default array
// geometry, the FSM state encoding and a small width helper.
package result_serializer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROW   = 4;
  localparam int DEF_COL   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit counter
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Word-in / beat-out stream bundle of the result serializer.
// With RESULT_SERIALIZER_PARITY_EN defined the bundle also carries out_parity_o.
interface result_serializer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 8
);
  logic                  valid_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  out_ready_i;
  logic                  out_valid_o;
  logic [OUT_WIDTH-1:0]  out_data_o;
  logic                  out_last_o;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic                  out_parity_o;

  modport master (
    output valid_i, data_i, out_ready_i,
    input  out_valid_o, out_data_o, out_last_o, out_parity_o
  );
  modport slave (
    input  valid_i, data_i, out_ready_i,
    output out_valid_o, out_data_o, out_last_o, out_parity_o
  );
`else
  modport master (
    output valid_i, data_i, out_ready_i,
    input  out_valid_o, out_data_o, out_last_o
  );
  modport slave (
    input  valid_i, data_i, out_ready_i,
    output out_valid_o, out_data_o, out_last_o
  );
`endif
endinterface

// File: rtl/result_serializer_sync_fifo.sv
// Synchronous FIFO for whole result words. The caller is responsible for
// only pushing when not full (or popping on the same edge) and only popping
// when not empty. flush_i empties the FIFO on the next edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // pointer and occupancy update; power-of-2 depth lets pointers wrap freely
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // pointer/count registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; contents need no reset since occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;

endmodule

// File: rtl/result_serializer.sv
// Result serializer: buffers DATA_WIDTH-bit result words in a FIFO and
// streams each one out as DATA_WIDTH/OUT_WIDTH beats, LSB slice first.
// Optional feature macro: RESULT_SERIALIZER_PARITY_EN adds out_parity_o.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ROW        = DEF_ROW,
  parameter int COL        = DEF_COL,
  parameter int DATA_WIDTH = WIDTH * (ROW + COL),
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic                    flush_i,
  result_serializer_if.slave      bus,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int CW    = clog2_min1(BEATS);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ovf_q, ovf_d;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  assign fifo_flush = en_i && flush_i;
  // a pop on the same edge frees a slot, so a full FIFO still takes the word
  assign fifo_push  = en_i && !flush_i && bus.valid_i && (!fifo_full || fifo_pop);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (bus.data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // next-state for FSM, slice counter, shift register and sticky overflow
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    fifo_pop = 1'b0;
    if (en_i) begin
      if (flush_i) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
              cnt_d    = '0;
              valid_d  = 1'b1;
              last_d   = (BEATS == 1);
              state_d  = SHIFT;
            end
          end
          SHIFT: begin
            if (bus.out_ready_i) begin
              if (last_q) begin
                if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  cnt_d    = '0;
                  valid_d  = 1'b1;
                  last_d   = (BEATS == 1);
                end else begin
                  shift_d = '0;
                  cnt_d   = '0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = IDLE;
                end
              end else begin
                shift_d = shift_q >> OUT_WIDTH;
                cnt_d   = cnt_q + 1'b1;
                last_d  = (cnt_q == CW'(BEATS - 2));
              end
            end
          end
          default: state_d = IDLE;
        endcase
        if (bus.valid_i && fifo_full && !fifo_pop) ovf_d = 1'b1;
      end
    end
  end

  // state and registered stream outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid_o = valid_q;
  assign bus.out_data_o  = shift_q[OUT_WIDTH-1:0];
  assign bus.out_last_o  = last_q;
  assign overflow_o      = ovf_q;

`ifdef RESULT_SERIALIZER_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^shift_d[OUT_WIDTH-1:0];

  // parity registered alongside the beat it covers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) parity_q <= 1'b0;
    else         parity_q <= parity_d;
  end

  assign bus.out_parity_o = parity_q;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer (default geometry: 64-bit words,
// 8-bit beats, 4-entry FIFO).
module tb_result_serializer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic       overflow;
  logic [2:0] level;

  int n_checks = 0;
  int n_pass   = 0;

  result_serializer_if #(.DATA_WIDTH(64), .OUT_WIDTH(8)) bus ();

  result_serializer dut (
    .clk_i      (clk),
    .rstn_i     (rst_n),
    .en_i       (en),
    .flush_i    (flush),
    .bus        (bus),
    .overflow_o (overflow),
    .level_o    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receives beats first_b..7 of word w. The first beat must already be
  // showing when contig is set; otherwise wait a bounded number of cycles.
  // On beat stall_beat, ready is dropped for 'stalls' cycles.
  task automatic recv_word(input logic [63:0] w, input int first_b,
                           input int stall_beat, input int stalls, input bit contig);
    logic [63:0] wv;
    wv = w;
    bus.out_ready_i = 1'b1;
    for (int b = first_b; b < 8; b++) begin
      int wait_n;
      wait_n = 0;
      if (!contig && b == first_b)
        while (!bus.out_valid_o && wait_n < 20) begin
          step();
          wait_n++;
        end
      check("out_valid", 64'(bus.out_valid_o), 64'd1);
      check("beat_data", 64'(bus.out_data_o), 64'(wv[b*8 +: 8]));
      check("beat_last", 64'(bus.out_last_o), 64'(b == 7));
`ifdef RESULT_SERIALIZER_PARITY_EN
      check("beat_parity", 64'(bus.out_parity_o), 64'(^wv[b*8 +: 8]));
`endif
      if (b == stall_beat) begin
        bus.out_ready_i = 1'b0;
        for (int s = 0; s < stalls; s++) begin
          step();
          check("stall_valid", 64'(bus.out_valid_o), 64'd1);
          check("stall_data", 64'(bus.out_data_o), 64'(wv[b*8 +: 8]));
          check("stall_last", 64'(bus.out_last_o), 64'(b == 7));
        end
        bus.out_ready_i = 1'b1;
      end
      step();
    end
  endtask

  localparam logic [63:0] W1 = 64'h0807_0605_0403_0201;
  localparam logic [63:0] W2 = 64'h1817_1615_1413_1211;
  localparam logic [63:0] WA = 64'hA7A6_A5A4_A3A2_A1A0;
  localparam logic [63:0] WB = 64'hB7B6_B5B4_B3B2_B1B0;

  logic [63:0] ovf_words [6];

  initial begin
    ovf_words[0] = 64'hC0C1_C2C3_C4C5_C6C7;
    ovf_words[1] = 64'h1111_2222_3333_4444;
    ovf_words[2] = 64'h5555_6666_7777_8888;
    ovf_words[3] = 64'h9999_AAAA_BBBB_CCCC;
    ovf_words[4] = 64'hDEAD_BEEF_0BAD_F00D;
    ovf_words[5] = 64'hFFEE_DDCC_BBAA_9988;

    rst_n = 1'b0;
    en = 1'b1;
    flush = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    bus.out_ready_i = 1'b1;

    // reset state
    #12;
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_last", 64'(bus.out_last_o), 64'd0);
    check("rst_data", 64'(bus.out_data_o), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single word, ready held high; load one edge after the push
    bus.valid_i = 1'b1;
    bus.data_i = W1;
    step();
    check("push_level", 64'(level), 64'd1);
    check("push_valid", 64'(bus.out_valid_o), 64'd0);
    bus.valid_i = 1'b0;
    step();
    check("load_level", 64'(level), 64'd0);
    recv_word(W1, 0, -1, 0, 1'b1);
    check("single_idle", 64'(bus.out_valid_o), 64'd0);

    // backpressure on beat 2
    bus.valid_i = 1'b1;
    bus.data_i = W2;
    step();
    bus.valid_i = 1'b0;
    step();
    recv_word(W2, 0, 2, 3, 1'b1);
    check("bp_idle", 64'(bus.out_valid_o), 64'd0);

    // back-to-back words, no bubble between last and next first beat
    bus.valid_i = 1'b1;
    bus.data_i = WA;
    step();
    bus.data_i = WB;
    step();
    bus.valid_i = 1'b0;
    recv_word(WA, 0, -1, 0, 1'b1);
    recv_word(WB, 0, -1, 0, 1'b1);
    check("b2b_idle", 64'(bus.out_valid_o), 64'd0);

    // overflow: shift register absorbs word 0, FIFO fills with 1..4, 5 drops
    bus.out_ready_i = 1'b0;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.data_i = ovf_words[i];
      step();
      if (i == 4) begin
        check("full_level", 64'(level), 64'd4);
        check("full_no_ovf", 64'(overflow), 64'd0);
      end
    end
    bus.valid_i = 1'b0;
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    for (int i = 0; i < 5; i++) recv_word(ovf_words[i], 0, -1, 0, 1'b1);
    check("drain_idle", 64'(bus.out_valid_o), 64'd0);
    check("drain_level", 64'(level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ovf", 64'(overflow), 64'd0);
    check("flush_level", 64'(level), 64'd0);

    // flush with words queued and a simultaneous valid_i
    bus.out_ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i = WA;
    step();
    bus.data_i = WB;
    step();
    bus.data_i = W1;
    step();
    check("pre_flush_level", 64'(level), 64'd2);
    flush = 1'b1;
    bus.data_i = W2;
    step();
    flush = 1'b0;
    bus.valid_i = 1'b0;
    check("flush2_level", 64'(level), 64'd0);
    check("flush2_valid", 64'(bus.out_valid_o), 64'd0);
    step();
    step();
    check("flush2_quiet", 64'(bus.out_valid_o), 64'd0);
    check("flush2_quiet_lvl", 64'(level), 64'd0);

    // enable low mid-word freezes everything, including input pushes
    bus.out_ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i = W2;
    step();
    bus.valid_i = 1'b0;
    step();
    for (int b = 0; b < 3; b++) begin
      check("en_pre_data", 64'(bus.out_data_o), 64'(8'h11 + b));
      step();
    end
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.valid_i = (c == 1 || c == 2);
      bus.data_i = W1;
      step();
      check("en_hold_data", 64'(bus.out_data_o), 64'h14);
      check("en_hold_valid", 64'(bus.out_valid_o), 64'd1);
      check("en_no_push", 64'(level), 64'd0);
      check("en_no_ovf", 64'(overflow), 64'd0);
    end
    bus.valid_i = 1'b0;
    en = 1'b1;
    recv_word(W2, 3, -1, 0, 1'b1);
    check("en_idle", 64'(bus.out_valid_o), 64'd0);
    check("en_level", 64'(level), 64'd0);

    // async reset at beat 5
    bus.valid_i = 1'b1;
    bus.data_i = W1;
    step();
    bus.valid_i = 1'b0;
    step();
    for (int b = 0; b < 5; b++) step();
    check("pre_rst_data", 64'(bus.out_data_o), 64'h06);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid_o), 64'd0);
    check("arst_data", 64'(bus.out_data_o), 64'd0);
    check("arst_last", 64'(bus.out_last_o), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("post_rst_quiet", 64'(bus.out_valid_o), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
